// File: rtl/flight_phase_sequencer.sv
// Flight-profile stimulus for the cabin controller: dwell-timed phase sequencing,
// rate-limited crew lighting pulses, fault stretching and maintenance gating.
module flight_phase_sequencer #(
   parameter int unsigned DWELL_CYCLES  = 25,
   parameter int unsigned CRUISE_CYCLES = 200,
   parameter int unsigned LIGHT_GAP     = 60,
   parameter int unsigned FAULT_HOLD    = 10
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic       abort,
   input  logic       light_req,
   input  logic       fault_in,
   input  logic       maint_req,
   output logic [2:0] flight_phase,
   output logic       lighting_cmd,
   output logic       fault_detected,
   output logic       maintenance_mode,
   output logic       busy,
   output logic       done
);

   localparam int unsigned DwellMax = (CRUISE_CYCLES > DWELL_CYCLES) ? CRUISE_CYCLES
                                                                      : DWELL_CYCLES;
   localparam int unsigned DwellW   = $clog2(DwellMax + 1);
   localparam int unsigned GapW     = $clog2(LIGHT_GAP + 1);
   localparam int unsigned HoldW    = $clog2(FAULT_HOLD + 1);

   // Low three bits are the phase code; IDLE sets bit 3 so it reads out as 000.
   localparam logic [3:0] StGround  = 4'b0000;
   localparam logic [3:0] StTaxi    = 4'b0001;
   localparam logic [3:0] StTakeoff = 4'b0010;
   localparam logic [3:0] StClimb   = 4'b0011;
   localparam logic [3:0] StCruise  = 4'b0100;
   localparam logic [3:0] StDescent = 4'b0101;
   localparam logic [3:0] StLanding = 4'b0110;
   localparam logic [3:0] StIdle    = 4'b1000;

   // Counters run down to zero, so a load of N-1 holds the phase N cycles.
   localparam logic [DwellW-1:0] DwellLoad  = DwellW'(DWELL_CYCLES - 1);
   localparam logic [DwellW-1:0] CruiseLoad = DwellW'(CRUISE_CYCLES - 1);
   localparam logic [GapW-1:0]   GapLoad    = GapW'(LIGHT_GAP);
   localparam logic [HoldW-1:0]  HoldLoad   = HoldW'(FAULT_HOLD);

   logic [3:0]        state_q, state_d;
   logic [DwellW-1:0] dwell_q, dwell_d;
   logic [GapW-1:0]   gap_q, gap_d;
   logic [HoldW-1:0]  hold_q, hold_d;
   logic              light_q, rise_q;
   logic              pend_q, pend_d;
   logic              cmd_q, cmd_d;
   logic              fdet_q, fdet_d;
   logic              maint_q, maint_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              in_cruise;

   always_comb begin
      state_d = state_q;
      dwell_d = dwell_q;
      done_d  = 1'b0;
      if (state_q == StIdle) begin
         if (start && !maint_q) begin
            state_d = StGround;
            dwell_d = DwellLoad;
         end
      end else if (abort && (state_q != StLanding)) begin
         if ((state_q == StGround) || (state_q == StTaxi)) begin
            state_d = StIdle;
            dwell_d = '0;
         end else begin
            state_d = StLanding;
            dwell_d = DwellLoad;
         end
      end else if (dwell_q != '0) begin
         dwell_d = dwell_q - DwellW'(1);
      end else if (state_q == StLanding) begin
         state_d = StIdle;
         done_d  = 1'b1;
      end else begin
         state_d = state_q + 4'd1;
         dwell_d = (state_q == StClimb) ? CruiseLoad : DwellLoad;
      end
   end

   // A pending request fires on the cycle the gap counter drains to zero.
   always_comb begin
      in_cruise = (state_q == StCruise);
      cmd_d     = in_cruise && ((rise_q && (gap_q == '0)) ||
                                (pend_q && (gap_q <= GapW'(1))));
      if (cmd_d) begin
         gap_d = GapLoad;
      end else if (gap_q != '0) begin
         gap_d = gap_q - GapW'(1);
      end else begin
         gap_d = '0;
      end
      if (!in_cruise || cmd_d) begin
         pend_d = 1'b0;
      end else if (rise_q && (gap_q != '0)) begin
         pend_d = 1'b1;
      end else begin
         pend_d = pend_q;
      end
   end

   always_comb begin
      hold_d = '0;
      fdet_d = 1'b0;
      if (fault_in) begin
         hold_d = HoldLoad;
         fdet_d = 1'b1;
      end else if (hold_q != '0) begin
         hold_d = hold_q - HoldW'(1);
         fdet_d = 1'b1;
      end
   end

   always_comb begin
      maint_d = maint_req && (state_d == StIdle);
      busy_d  = (state_d != StIdle);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= StIdle;
         dwell_q <= '0;
         gap_q   <= '0;
         hold_q  <= '0;
         light_q <= 1'b0;
         rise_q  <= 1'b0;
         pend_q  <= 1'b0;
         cmd_q   <= 1'b0;
         fdet_q  <= 1'b0;
         maint_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         dwell_q <= dwell_d;
         gap_q   <= gap_d;
         hold_q  <= hold_d;
         light_q <= light_req;
         rise_q  <= light_req && !light_q;
         pend_q  <= pend_d;
         cmd_q   <= cmd_d;
         fdet_q  <= fdet_d;
         maint_q <= maint_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign flight_phase     = state_q[2:0];
   assign lighting_cmd     = cmd_q;
   assign fault_detected   = fdet_q;
   assign maintenance_mode = maint_q;
   assign busy             = busy_q;
   assign done             = done_q;

endmodule
